// File: rtl/l2_sched_pkg.sv
// Shared types and sizing for the L2 cache sequencing controller.
// L2 capacity and beat width are counted in 16-bit words.
package l2_sched_pkg;

  localparam int L2_WORDS          = 4096;
  localparam int L2_WORDS_PER_BEAT = 8;
  localparam int L2_SIZE_W         = 12;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CMD   = 2'd1,
    BURST = 2'd2
  } sched_state_e;

endpackage

// File: rtl/l2_dirty_counter.sv
// Saturating count of dirty 16-bit words in L2: +1 per L1 write, -8 per
// writeback beat, clamped to 0..L2_WORDS-1.
module l2_dirty_counter
  import l2_sched_pkg::*;
(
  input  logic                 clk_166M66,
  input  logic                 mcu_sys_rst_n,
  input  logic                 inc,
  input  logic                 dec8,
  output logic [L2_SIZE_W-1:0] count
);

  typedef logic [L2_SIZE_W+1:0] wide_t;

  localparam wide_t BEAT_WORDS = wide_t'(L2_WORDS_PER_BEAT);
  localparam wide_t MAX_WORDS  = wide_t'(L2_WORDS - 1);

  wide_t                 up;
  logic [L2_SIZE_W-1:0] count_next;

  // Add first, then subtract, so a write and a beat together net to -7.
  always_comb begin
    up         = {2'b00, count} + {{(L2_SIZE_W + 1){1'b0}}, inc};
    count_next = count;
    if (dec8) begin
      if (up < BEAT_WORDS) count_next = '0;
      else                 count_next = up[L2_SIZE_W-1:0] - BEAT_WORDS[L2_SIZE_W-1:0];
    end else if (up > MAX_WORDS) begin
      count_next = '1;
    end else begin
      count_next = up[L2_SIZE_W-1:0];
    end
  end

  always_ff @(posedge clk_166M66 or negedge mcu_sys_rst_n) begin
    if (!mcu_sys_rst_n) count <= '0;
    else                count <= count_next;
  end

endmodule

// File: rtl/l2_cache_sched.sv
// Sequencing controller for the dual-port L2: grants L1 beats each cycle and
// schedules DDR refill/writeback bursts from the unread and dirty levels.
module l2_cache_sched
  import l2_sched_pkg::*;
#(
  parameter int                   BURST_BEATS = 8,
  parameter logic [L2_SIZE_W-1:0] REFILL_LOW  = 12'd1024,
  parameter logic [L2_SIZE_W-1:0] WB_HIGH     = 12'd512
) (
  input  logic                 clk_166M66,
  input  logic                 mcu_sys_rst_n,
  input  logic [L2_SIZE_W-1:0] i_l2_unread_size,
  input  logic                 i_l1ddr_rw_confilicts,
  input  logic                 i_l1_req,
  input  logic                 i_l1_req_rw,
  output logic                 o_l1_operate_enable,
  output logic                 o_l1_rw,
  output logic                 o_ddr_cmd_valid,
  output logic                 o_ddr_cmd_rw,
  output logic [6:0]           o_ddr_cmd_len,
  input  logic                 i_ddr_cmd_ready,
  input  logic                 i_ddr_beat_valid,
  output logic                 o_ddr_operate_enable,
  output logic                 o_ddr_rw,
  output logic [L2_SIZE_W-1:0] o_dirty_words,
  output logic                 o_busy
);

  localparam int                   BURST_WORDS = BURST_BEATS * L2_WORDS_PER_BEAT;
  localparam logic [L2_SIZE_W-1:0] REFILL_MAX  = L2_SIZE_W'(L2_WORDS - 1 - BURST_WORDS);
  localparam logic [L2_SIZE_W-1:0] WB_MIN      = L2_SIZE_W'(BURST_WORDS);
  localparam logic [L2_SIZE_W-1:0] DIRTY_FULL  = L2_SIZE_W'(L2_WORDS - 1);
  localparam logic [6:0]           LEN         = 7'(BURST_BEATS);
  localparam logic [6:0]           LAST_BEAT   = 7'(BURST_BEATS - 1);

  // Command handshake (valid/ready): o_ddr_cmd_valid rises in CMD and holds
  // with rw/len unchanged until a cycle where i_ddr_cmd_ready is also high;
  // that cycle transfers the command. Beats then move on i_ddr_beat_valid.
  sched_state_e state, state_next;
  logic         ddr_rw_q, ddr_rw_next;
  logic [6:0]   beat_cnt, beat_cnt_next;
  logic         wb_due, refill_due, stall, grant;

  assign wb_due     = (o_dirty_words >= WB_HIGH) && (o_dirty_words >= WB_MIN);
  assign refill_due = (i_l2_unread_size < REFILL_LOW) && (i_l2_unread_size <= REFILL_MAX);

  always_ff @(posedge clk_166M66 or negedge mcu_sys_rst_n) begin
    if (!mcu_sys_rst_n) begin
      state    <= IDLE;
      ddr_rw_q <= 1'b0;
      beat_cnt <= '0;
    end else begin
      state    <= state_next;
      ddr_rw_q <= ddr_rw_next;
      beat_cnt <= beat_cnt_next;
    end
  end

  always_comb begin
    state_next    = state;
    ddr_rw_next   = ddr_rw_q;
    beat_cnt_next = beat_cnt;
    case (state)
      IDLE: begin
        // Writeback has priority: draining dirty data frees room for refills.
        if (wb_due) begin
          state_next  = CMD;
          ddr_rw_next = 1'b0;
        end else if (refill_due) begin
          state_next  = CMD;
          ddr_rw_next = 1'b1;
        end
      end
      CMD: begin
        if (i_ddr_cmd_ready) begin
          state_next    = BURST;
          beat_cnt_next = '0;
        end
      end
      BURST: begin
        if (i_ddr_beat_valid) begin
          beat_cnt_next = beat_cnt + 7'd1;
          if (beat_cnt == LAST_BEAT) state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Reset gates the combinational strobes so nothing reaches the cache in reset.
  assign stall = ((state == BURST) && i_l1ddr_rw_confilicts)
              || (!i_l1_req_rw && (i_l2_unread_size == '0))
              || ( i_l1_req_rw && (o_dirty_words == DIRTY_FULL));
  assign grant = mcu_sys_rst_n && i_l1_req && !stall;

  assign o_l1_operate_enable  = grant;
  assign o_l1_rw              = grant && i_l1_req_rw;
  assign o_ddr_cmd_valid      = (state == CMD);
  assign o_ddr_cmd_rw         = ddr_rw_q;
  assign o_ddr_cmd_len        = mcu_sys_rst_n ? LEN : 7'd0;
  assign o_ddr_operate_enable = (state == BURST) && i_ddr_beat_valid;
  assign o_ddr_rw             = ddr_rw_q;
  assign o_busy               = (state != IDLE);

  l2_dirty_counter u_dirty (
    .clk_166M66    (clk_166M66),
    .mcu_sys_rst_n (mcu_sys_rst_n),
    .inc           (grant && i_l1_req_rw),
    .dec8          (o_ddr_operate_enable && !ddr_rw_q),
    .count         (o_dirty_words)
  );

endmodule

// File: tb/tb_l2_cache_sched.sv
// Randomized and directed bench for l2_cache_sched with a queue-based scoreboard
// fed by a word-count reference model of the scheduler.
module tb_l2_cache_sched;

  localparam int BB         = 8;
  localparam int WB_HIGH    = 512;
  localparam int REFILL_LOW = 1024;
  localparam int M_IDLE     = 0;
  localparam int M_CMD      = 1;
  localparam int M_BURST    = 2;

  logic        clk_166M66 = 1'b0;
  logic        mcu_sys_rst_n;
  logic [11:0] i_l2_unread_size;
  logic        i_l1ddr_rw_confilicts, i_l1_req, i_l1_req_rw;
  logic        i_ddr_cmd_ready, i_ddr_beat_valid;
  logic        o_l1_operate_enable, o_l1_rw, o_ddr_cmd_valid, o_ddr_cmd_rw;
  logic [6:0]  o_ddr_cmd_len;
  logic        o_ddr_operate_enable, o_ddr_rw, o_busy;
  logic [11:0] o_dirty_words;

  l2_cache_sched #(.BURST_BEATS(BB), .REFILL_LOW(12'd1024), .WB_HIGH(12'd512)) dut (
    .clk_166M66            (clk_166M66),
    .mcu_sys_rst_n         (mcu_sys_rst_n),
    .i_l2_unread_size      (i_l2_unread_size),
    .i_l1ddr_rw_confilicts (i_l1ddr_rw_confilicts),
    .i_l1_req              (i_l1_req),
    .i_l1_req_rw           (i_l1_req_rw),
    .o_l1_operate_enable   (o_l1_operate_enable),
    .o_l1_rw               (o_l1_rw),
    .o_ddr_cmd_valid       (o_ddr_cmd_valid),
    .o_ddr_cmd_rw          (o_ddr_cmd_rw),
    .o_ddr_cmd_len         (o_ddr_cmd_len),
    .i_ddr_cmd_ready       (i_ddr_cmd_ready),
    .i_ddr_beat_valid      (i_ddr_beat_valid),
    .o_ddr_operate_enable  (o_ddr_operate_enable),
    .o_ddr_rw              (o_ddr_rw),
    .o_dirty_words         (o_dirty_words),
    .o_busy                (o_busy)
  );

  // ---------------- clock / reset ----------------
  always #3 clk_166M66 = ~clk_166M66;

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  logic [5:0]  exp_q[$];   // {l1_en, l1_rw, ddr_en, cmd_valid, busy, ddr_rw}
  logic [11:0] dirty_q[$];
  logic        cmd_q[$];

  // Reference model: phase of the DDR side, beats still owed, dirty words.
  int ph        = M_IDLE;
  int beats_left = 0;
  int dirty_m   = 0;
  bit rw_m      = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: bound expired at %0t", name, $time);
  endtask

  task automatic model_reset();
    ph = M_IDLE; beats_left = 0; dirty_m = 0; rw_m = 1'b0;
    exp_q.delete(); dirty_q.delete(); cmd_q.delete();
  endtask

  // ---------------- driver ----------------
  task automatic drive_cycle(input logic req, input logic rw, input logic conf,
                             input int unread, input logic ready, input logic beat);
    bit in_burst, stall, l1_en, ddr_en;
    int nd;
    @(negedge clk_166M66);
    i_l1_req = req; i_l1_req_rw = rw; i_l1ddr_rw_confilicts = conf;
    i_l2_unread_size = 12'(unread); i_ddr_cmd_ready = ready; i_ddr_beat_valid = beat;

    in_burst = (ph == M_BURST);
    stall    = (in_burst && conf) || (!rw && unread == 0) || (rw && dirty_m == 4095);
    l1_en    = req && !stall;
    ddr_en   = in_burst && beat;
    exp_q.push_back({l1_en, l1_en && rw, ddr_en, ph == M_CMD, ph != M_IDLE, rw_m});

    nd = dirty_m + ((l1_en && rw) ? 1 : 0) - ((ddr_en && !rw_m) ? 8 : 0);
    if (nd < 0) nd = 0;
    if (nd > 4095) nd = 4095;
    dirty_q.push_back(12'(nd));

    case (ph)
      M_IDLE: begin
        if (dirty_m >= WB_HIGH && dirty_m >= 8 * BB) begin
          ph = M_CMD; rw_m = 1'b0; cmd_q.push_back(1'b0);
        end else if (unread < REFILL_LOW && unread <= 4095 - 8 * BB) begin
          ph = M_CMD; rw_m = 1'b1; cmd_q.push_back(1'b1);
        end
      end
      M_CMD: if (ready) begin ph = M_BURST; beats_left = BB; end
      default: if (beat) begin
        beats_left--;
        if (beats_left == 0) ph = M_IDLE;
      end
    endcase
    dirty_m = nd;
  endtask

  task automatic idle_cycle();
    drive_cycle(1'b0, 1'b0, 1'b0, 2000, 1'b0, 1'b0);
  endtask

  // Accept the pending command and stream beats until the model is idle.
  task automatic finish_burst(input string name);
    int n = 0;
    while (ph != M_IDLE && n < 200) begin
      drive_cycle(1'b0, 1'b0, 1'b0, 2000, 1'b1, 1'b1);
      n++;
    end
    if (ph != M_IDLE) fail_now(name);
  endtask

  // ---------------- monitors ----------------
  always @(negedge clk_166M66) begin
    logic [5:0] exp, act;
    logic       exp_rw;
    #1;
    if (exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      act = {o_l1_operate_enable, o_l1_rw, o_ddr_operate_enable, o_ddr_cmd_valid, o_busy, o_ddr_rw};
      checks++;
      if (act !== exp) begin
        errors++;
        $display("FAIL strobes {l1_en,l1_rw,ddr_en,cmd_v,busy,ddr_rw}: got %b expected %b at %0t",
                 act, exp, $time);
      end
    end
    if (o_ddr_cmd_valid && i_ddr_cmd_ready) begin
      if (cmd_q.size() == 0) begin
        fail_now("cmd_unexpected");
      end else begin
        exp_rw = cmd_q.pop_front();
        chk("cmd_rw", int'(o_ddr_cmd_rw), int'(exp_rw));
        chk("cmd_len", int'(o_ddr_cmd_len), BB);
      end
    end
  end

  always @(posedge clk_166M66) begin
    logic [11:0] exp_d;
    #1;
    if (dirty_q.size() > 0) begin
      exp_d = dirty_q.pop_front();
      chk("dirty_words", int'(o_dirty_words), int'(exp_d));
    end
  end

  task automatic check_all_zero(input string tag);
    chk({tag, "_l1_en"},  int'(o_l1_operate_enable), 0);
    chk({tag, "_l1_rw"},  int'(o_l1_rw), 0);
    chk({tag, "_cmd_v"},  int'(o_ddr_cmd_valid), 0);
    chk({tag, "_cmd_rw"}, int'(o_ddr_cmd_rw), 0);
    chk({tag, "_len"},    int'(o_ddr_cmd_len), 0);
    chk({tag, "_ddr_en"}, int'(o_ddr_operate_enable), 0);
    chk({tag, "_ddr_rw"}, int'(o_ddr_rw), 0);
    chk({tag, "_dirty"},  int'(o_dirty_words), 0);
    chk({tag, "_busy"},   int'(o_busy), 0);
  endtask

  task automatic set_benign();
    i_l1_req = 1'b0; i_l1_req_rw = 1'b0; i_l1ddr_rw_confilicts = 1'b0;
    i_l2_unread_size = 12'd2000; i_ddr_cmd_ready = 1'b0; i_ddr_beat_valid = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    // Reset with an active L1 request and a live DDR side.
    mcu_sys_rst_n = 1'b0;
    i_l1_req = 1'b1; i_l1_req_rw = 1'b0; i_l1ddr_rw_confilicts = 1'b0;
    i_l2_unread_size = 12'd100; i_ddr_cmd_ready = 1'b1; i_ddr_beat_valid = 1'b1;
    #1;
    check_all_zero("reset");
    repeat (3) @(posedge clk_166M66);
    @(negedge clk_166M66);
    set_benign();
    #1 mcu_sys_rst_n = 1'b1;
    model_reset();
    idle_cycle();

    // Refill: command holds for 5 cycles with ready low, then 8 beats.
    drive_cycle(1'b0, 1'b0, 1'b0, 100, 1'b0, 1'b0);
    repeat (5) drive_cycle(1'b0, 1'b0, 1'b0, 2000, 1'b0, 1'b0);
    drive_cycle(1'b0, 1'b0, 1'b0, 2000, 1'b1, 1'b0);
    for (int i = 0; i < BB; i++) drive_cycle(1'b0, 1'b0, 1'b0, 2000, 1'b0, 1'b1);
    idle_cycle();

    // Writeback priority: 512 writes, then both triggers due at once.
    for (int i = 0; i < 512; i++) drive_cycle(1'b1, 1'b1, 1'b0, 2000, 1'b0, 1'b0);
    drive_cycle(1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    finish_burst("wb_burst");
    idle_cycle();
    #1 chk("dirty_after_wb", int'(o_dirty_words), 448);

    // Conflict stall in BURST, then same-cycle grant and write+beat net -7.
    for (int i = 0; i < 64; i++) drive_cycle(1'b1, 1'b1, 1'b0, 2000, 1'b0, 1'b0);
    idle_cycle();
    drive_cycle(1'b0, 1'b0, 1'b0, 2000, 1'b1, 1'b0);
    drive_cycle(1'b1, 1'b1, 1'b1, 2000, 1'b0, 1'b0);
    #1 chk("conflict_stall", int'(o_l1_operate_enable), 0);
    drive_cycle(1'b1, 1'b1, 1'b0, 2000, 1'b0, 1'b1);
    #1 chk("conflict_clear_grant", int'(o_l1_operate_enable), 1);
    drive_cycle(1'b0, 1'b0, 1'b0, 2000, 1'b0, 1'b0);
    #1 chk("dirty_net_minus7", int'(o_dirty_words), 505);
    finish_burst("conflict_burst");

    // Read with nothing unread is never granted.
    drive_cycle(1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    #1 chk("read_empty_stall", int'(o_l1_operate_enable), 0);
    finish_burst("refill_after_empty");

    // Saturate dirty: park the writeback command and keep writing.
    n = 0;
    while (dirty_m < 4095 && n < 5000) begin
      drive_cycle(1'b1, 1'b1, 1'b0, 2000, 1'b0, 1'b0);
      n++;
    end
    if (dirty_m < 4095) fail_now("saturate_timeout");
    drive_cycle(1'b1, 1'b1, 1'b0, 2000, 1'b0, 1'b0);
    #1 chk("write_full_stall", int'(o_l1_operate_enable), 0);
    drive_cycle(1'b0, 1'b0, 1'b0, 2000, 1'b0, 1'b0);
    #1 chk("dirty_held_full", int'(o_dirty_words), 4095);
    finish_burst("full_wb_burst");

    // Random traffic on both sides.
    for (int i = 0; i < 3000; i++) begin
      int u;
      case ($urandom_range(0, 3))
        0:       u = 0;
        1:       u = 100;
        2:       u = $urandom_range(0, 4095);
        default: u = 2000;
      endcase
      drive_cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 3) == 0), u,
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    finish_burst("random_tail");

    // Reset after beat 3 of a refill burst.
    n = 0;
    while (ph != M_CMD && n < 50) begin
      drive_cycle(1'b0, 1'b0, 1'b0, 100, 1'b0, 1'b0);
      n++;
    end
    if (ph != M_CMD) fail_now("mid_reset_cmd_timeout");
    drive_cycle(1'b1, 1'b1, 1'b0, 2000, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) drive_cycle(1'b1, 1'b1, 1'b0, 2000, 1'b0, 1'b1);
    @(negedge clk_166M66);
    i_ddr_beat_valid = 1'b1; i_l1_req = 1'b1; i_l1_req_rw = 1'b1;
    i_l1ddr_rw_confilicts = 1'b0; i_l2_unread_size = 12'd2000;
    #1 chk("pre_reset_ddr_en", int'(o_ddr_operate_enable), 1);
    mcu_sys_rst_n = 1'b0;
    model_reset();
    #1 check_all_zero("mid_reset");
    repeat (2) @(negedge clk_166M66);
    set_benign();
    #1 mcu_sys_rst_n = 1'b1;
    idle_cycle();
    drive_cycle(1'b0, 1'b0, 1'b0, 100, 1'b0, 1'b0);
    drive_cycle(1'b0, 1'b0, 1'b0, 2000, 1'b0, 1'b0);
    finish_burst("fresh_burst");

    // Drain: let any outstanding writebacks complete.
    n = 0;
    while (!(ph == M_IDLE && dirty_m < WB_HIGH) && n < 3000) begin
      drive_cycle(1'b0, 1'b0, 1'b0, 2000, 1'b1, 1'b1);
      n++;
    end
    if (!(ph == M_IDLE && dirty_m < WB_HIGH)) fail_now("drain_timeout");
    repeat (3) idle_cycle();
    @(posedge clk_166M66);
    #2;
    chk("cmd_q_empty", cmd_q.size(), 0);
    chk("exp_q_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
